// File: rtl/fir_param.sv
// Parametrised, fully pipelined signed direct-form FIR with run-time coefficients,
// a valid-tag pipeline, rounding right-shift and signed output saturation.
module fir_param #(
  parameter int DW    = 8,
  parameter int CW    = 8,
  parameter int TAPS  = 8,
  parameter int OW    = 16,
  parameter int SHIFT = 0,
  localparam int L    = $clog2(TAPS),
  localparam int AKW  = (L > 1) ? L : 1,
  localparam int AW   = DW + CW + L
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic signed [DW-1:0] in,
  input  logic                 in_valid,
  input  logic                 coef_we,
  input  logic [AKW-1:0]       coef_addr,
  input  logic signed [CW-1:0] coef_din,
  output logic signed [OW-1:0] op,
  output logic                 op_valid,
  output logic                 sat
);

  localparam int EW  = (AW + 1 > OW) ? AW + 1 : OW;
  localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic [AW:0] RND = (SHIFT > 0) ? ((AW + 1)'(1) << RSH) : '0;
  localparam logic signed [EW-1:0] MAX_V = {{(EW - OW + 1){1'b0}}, {(OW - 1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  logic signed [DW-1:0]    x [TAPS];
  logic signed [CW-1:0]    c [TAPS];
  logic signed [DW+CW-1:0] p [TAPS];
  logic                    x_vld;
  logic [L:0]              vld_sr;
  logic signed [AW-1:0]    acc;

  // NOTE: sequential state is always assigned with <= so every register samples
  // the pre-edge value of its neighbours; with = the delay line would collapse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: these arrays are deliberately reset: a mid-stream reset must leave a
      // zeroed history, so they cannot be mapped to reset-less RAM.
      for (int i = 0; i < TAPS; i++) x[i] <= '0;
      x_vld <= 1'b0;
    end else begin
      x_vld <= in_valid;
      if (in_valid) begin
        x[0] <= in;
        for (int i = 1; i < TAPS; i++) x[i] <= x[i-1];
      end
    end
  end

  // Powers up as a pass-through: c[0]=1, all other taps zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) c[i] <= (i == 0) ? CW'(1) : '0;
    end else if (coef_we) begin
      c[coef_addr] <= coef_din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) p[i] <= '0;
      vld_sr <= '0;
    end else begin
      for (int i = 0; i < TAPS; i++) p[i] <= c[i] * x[i];
      vld_sr <= {vld_sr[L-1:0], x_vld};
    end
  end

  // Adder tree: level k holds TAPS>>k sums, each one bit wider than its operands.
  for (genvar k = 1; k <= L; k++) begin : g_lvl
    localparam int N = TAPS >> k;
    localparam int W = DW + CW + k;
    logic signed [W-2:0] a [2*N];
    logic signed [W-1:0] s [N];

    if (k == 1) begin : g_src
      assign a = p;
    end else begin : g_src
      assign a = g_lvl[k-1].s;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int j = 0; j < N; j++) s[j] <= '0;
      end else begin
        for (int j = 0; j < N; j++) s[j] <= W'(a[2*j]) + W'(a[2*j+1]);
      end
    end
  end

  assign acc = g_lvl[L].s[0];

  logic signed [AW:0]    rnd_sum;
  logic signed [AW:0]    r_full;
  logic signed [EW-1:0]  r_ext;
  logic signed [OW-1:0]  op_nxt;
  logic                  sat_nxt;

  // Round-half-up at AW+1 bits so adding the half-LSB can never wrap.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    op_nxt  = '0;
    sat_nxt = 1'b0;
    rnd_sum = {acc[AW-1], acc} + RND;
    r_full  = rnd_sum >>> SHIFT;
    r_ext   = EW'(r_full);
    if (r_ext > MAX_V) begin
      op_nxt  = MAX_V[OW-1:0];
      sat_nxt = 1'b1;
    end else if (r_ext < MIN_V) begin
      op_nxt  = MIN_V[OW-1:0];
      sat_nxt = 1'b1;
    end else begin
      op_nxt  = r_ext[OW-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op       <= '0;
      sat      <= 1'b0;
      op_valid <= 1'b0;
    end else begin
      op       <= op_nxt;
      sat      <= sat_nxt;
      op_valid <= vld_sr[L];
    end
  end

endmodule

// File: tb/tb_fir_param.sv
// Scoreboard bench for fir_param: a SHIFT=0 and a SHIFT=2 instance share stimulus and
// are compared against an arithmetic convolution model with rounding and clipping.
module tb_fir_param;
  localparam int DW = 8, CW = 8, TAPS = 8, OW = 16, LAT = 5;

  logic clk = 1'b0;
  logic rst;
  logic signed [DW-1:0] in;
  logic in_valid, coef_we;
  logic [2:0] coef_addr;
  logic signed [CW-1:0] coef_din;
  logic signed [OW-1:0] op0, op1;
  logic v0, v1, s0, s1;

  always #5 clk = ~clk;

  fir_param #(.DW(DW), .CW(CW), .TAPS(TAPS), .OW(OW), .SHIFT(0)) dut (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_din(coef_din), .op(op0), .op_valid(v0), .sat(s0));

  fir_param #(.DW(DW), .CW(CW), .TAPS(TAPS), .OW(OW), .SHIFT(2)) dut_r (
    .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .coef_we(coef_we),
    .coef_addr(coef_addr), .coef_din(coef_din), .op(op1), .op_valid(v1), .sat(s1));

  typedef struct { longint val; bit sat; int due; } exp_t;

  exp_t   exp_q [2][$];
  int     n_checks = 0;
  int     n_fail = 0;
  int     cyc = 0;
  longint hist [TAPS];
  longint coef [TAPS];
  int     shifts [2] = '{0, 2};

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t predict(input longint acc, input int sh, input int due);
    exp_t   e;
    longint r, hi, lo;
    hi = (longint'(1) << (OW - 1)) - 1;
    lo = -(longint'(1) << (OW - 1));
    r  = acc;
    if (sh > 0) r = (acc + (longint'(1) << (sh - 1))) >>> sh;
    e.due = due;
    e.sat = (r > hi) || (r < lo);
    e.val = (r > hi) ? hi : (r < lo) ? lo : r;
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < TAPS; i++) begin
      hist[i] = 0;
      coef[i] = (i == 0) ? 1 : 0;
    end
    for (int k = 0; k < 2; k++) exp_q[k].delete();
  endtask

  // One clock: present inputs, let the edge happen, then apply the same rules to the model.
  task automatic cycle(input bit v, input longint d, input bit we = 1'b0,
                       input int a = 0, input longint cd = 0);
    longint acc;
    in_valid  = v;
    in        = DW'(d);
    coef_we   = we;
    coef_addr = 3'(a);
    coef_din  = CW'(cd);
    @(posedge clk);
    cyc++;
    if (!rst) begin
      if (we) coef[a] = cd;
      if (v) begin
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        acc = 0;
        for (int i = 0; i < TAPS; i++) acc += coef[i] * hist[i];
        for (int k = 0; k < 2; k++) exp_q[k].push_back(predict(acc, shifts[k], cyc + LAT));
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_op0", op0, 0);
    check("rst_valid0", v0, 0);
    check("rst_sat0", s0, 0);
    check("rst_op1", op1, 0);
    check("rst_valid1", v1, 0);
    check("rst_sat1", s1, 0);
    cycle(1'b0, 0);
    rst = 1'b0;
  endtask

  task automatic load_coefs(input longint base, input longint step);
    for (int i = 0; i < TAPS; i++) cycle(1'b0, 99, 1'b1, i, base + step * i);
  endtask

  task automatic mon(input int k, input logic signed [OW-1:0] o, input logic v, input logic s);
    exp_t e;
    if (v) begin
      if (exp_q[k].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_valid[%0d]: op_valid=1 op=%0d, expected no pulse (cycle %0d)", k, o, cyc);
      end else begin
        e = exp_q[k].pop_front();
        check($sformatf("op[%0d]", k), o, e.val);
        check($sformatf("sat[%0d]", k), s, e.sat);
        check($sformatf("latency[%0d]", k), cyc, e.due);
      end
    end else if (exp_q[k].size() > 0 && exp_q[k][0].due <= cyc) begin
      e = exp_q[k].pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL missing_valid[%0d]: op_valid=0, expected op=%0d due cycle %0d (cycle %0d)",
               k, e.val, e.due, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, op0, v0, s0);
      mon(1, op1, v1, s1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic signed [7:0] rv, rc;
    rst = 1'b1;
    in_valid = 1'b0; in = '0; coef_we = 1'b0; coef_addr = '0; coef_din = '0;
    model_reset();
    cycle(1'b0, 0);
    do_reset();

    // Pass-through defaults, then rounding on the SHIFT=2 instance.
    foreach (shifts[k]) begin end
    cycle(1'b1, 5); cycle(1'b1, -7); cycle(1'b1, 127); cycle(1'b1, -128);
    cycle(1'b0, 0); cycle(1'b0, 0);
    cycle(1'b1, 6); cycle(1'b1, -6); cycle(1'b1, 5); cycle(1'b1, -5);
    repeat (6) cycle(1'b0, 99);

    // Impulse response with c[i]=i+1.
    do_reset();
    load_coefs(1, 1);
    cycle(1'b1, 1);
    repeat (8) cycle(1'b1, 0);

    // Valid gaps: invalid cycles carry 99 which must be ignored.
    cycle(1'b1, 1);
    repeat (8) begin
      cycle(1'b0, 99);
      cycle(1'b1, 0);
    end
    repeat (6) cycle(1'b0, 99);

    // Saturation in both directions.
    load_coefs(-128, 0);
    repeat (8) cycle(1'b1, -128);
    load_coefs(127, 0);
    repeat (8) cycle(1'b1, -128);
    repeat (6) cycle(1'b0, 0);

    // Coefficient write on the edge after sample n only affects later samples.
    do_reset();
    cycle(1'b1, 1);
    cycle(1'b1, 1, 1'b1, 0, 3);
    cycle(1'b1, 1);
    repeat (6) cycle(1'b0, 0);

    // Reset with samples in flight, then confirm defaults and a zeroed history.
    cycle(1'b1, 7); cycle(1'b1, 7); cycle(1'b1, 7);
    do_reset();
    repeat (6) cycle(1'b0, 0);
    cycle(1'b0, 0, 1'b1, 1, 1);
    cycle(1'b1, 10); cycle(1'b1, 20);
    repeat (6) cycle(1'b0, 0);

    // Randomised stream with sporadic coefficient writes.
    repeat (600) begin
      rv = 8'($urandom());
      rc = 8'($urandom());
      cycle($urandom_range(0, 3) != 0, rv, $urandom_range(0, 7) == 0,
            int'($urandom_range(0, TAPS - 1)), rc);
    end

    repeat (10) cycle(1'b0, 0);
    check("drain[0]", exp_q[0].size(), 0);
    check("drain[1]", exp_q[1].size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
